// File: rtl/svm_ddag_pkg.sv
// Shared types and helpers for the DDAG SVM sequencer.
// State enum, pair arithmetic, width helpers, coefficient generator.
package svm_ddag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

  function automatic int n_pairs(int n);
    return n * (n - 1) / 2;
  endfunction

  // Row of pair (i,j), i<j: rows for lower class i are
  // listed with j descending from n-1.
  function automatic int pair_index(int i, int j, int n);
    int s;
    s = 0;
    for (int k = 0; k < i; k++) s += n - 1 - k;
    return s + (n - 1 - j);
  endfunction

  // Never returns 0 so a single-pair build keeps a 1-bit index.
  function automatic int clog2_min1(int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int cls_w(int n);
    return clog2_min1(n);
  endfunction

  function automatic int idx_w(int n);
    return clog2_min1(n_pairs(n));
  endfunction

  // Generated coefficient pattern; f = N_FEATURES selects the bias.
  function automatic logic [31:0] coeff_hash(int idx, int f);
    logic [31:0] x;
    x = 32'(idx) * 32'd40503 + 32'(f) * 32'd977 + 32'd12345;
    return x ^ (x >> 7);
  endfunction

endpackage

// File: rtl/svm_ddag_sequencer_if.sv
// Control/data bundle between the DDAG sequencer and its user.
// master: drives start/abort/svm_*; slave: drives pair, coeffs, result.
interface svm_ddag_sequencer_if #(
  parameter int N_CLASSES  = 10,
  parameter int N_FEATURES = 16,
  parameter int WEIGHT_W   = 8,
  parameter int BIAS_W     = 16
);
  import svm_ddag_pkg::*;

  localparam int CLS_W = cls_w(N_CLASSES);
  localparam int IDX_W = idx_w(N_CLASSES);

  logic                           start;
  logic                           abort;
  logic                           svm_ready;
  logic                           svm_class;
  logic                           busy;
  logic [IDX_W-1:0]               pair_idx;
  logic [CLS_W-1:0]               pair_lo;
  logic [CLS_W-1:0]               pair_hi;
  logic [WEIGHT_W*N_FEATURES-1:0] weight;
  logic [BIAS_W-1:0]              bias;
  logic                           ready;
  logic [CLS_W-1:0]               winner;

  modport master (
    output start, abort, svm_ready, svm_class,
    input  busy, pair_idx, pair_lo, pair_hi,
    input  weight, bias, ready, winner
  );

  modport slave (
    input  start, abort, svm_ready, svm_class,
    output busy, pair_idx, pair_lo, pair_hi,
    output weight, bias, ready, winner
  );

endinterface

// File: rtl/svm_coeff_rom.sv
// Coefficient ROM: pair row -> packed signed weights and bias.
// idx_i: row; weight_o: N_FEATURES x WEIGHT_W; bias_o: BIAS_W.
module svm_coeff_rom
  import svm_ddag_pkg::*;
#(
  parameter int N_PAIRS    = 45,
  parameter int N_FEATURES = 16,
  parameter int WEIGHT_W   = 8,
  parameter int BIAS_W     = 16
) (
  input  logic [clog2_min1(N_PAIRS)-1:0]  idx_i,
  output logic [WEIGHT_W*N_FEATURES-1:0] weight_o,
  output logic [BIAS_W-1:0]              bias_o
);

  // Rows past the table read as zero.
  always_comb begin
    weight_o = '0;
    bias_o   = '0;
    if (int'(idx_i) < N_PAIRS) begin
      for (int f = 0; f < N_FEATURES; f++) begin
        weight_o[f*WEIGHT_W +: WEIGHT_W] =
          WEIGHT_W'(coeff_hash(int'(idx_i), f));
      end
      bias_o = BIAS_W'(coeff_hash(int'(idx_i), N_FEATURES));
    end
  end

endmodule

// File: rtl/svm_ddag_sequencer.sv
// N-class one-vs-one DDAG walker for a shared sequential SVM MAC.
// clk/rst: clock, sync active-high reset; bus: slave side of the bundle.
module svm_ddag_sequencer
  import svm_ddag_pkg::*;
#(
  parameter int N_CLASSES  = 10,
  parameter int N_FEATURES = 16,
  parameter int WEIGHT_W   = 8,
  parameter int BIAS_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  svm_ddag_sequencer_if.slave bus
);

  localparam int CLS_W   = cls_w(N_CLASSES);
  localparam int IDX_W   = idx_w(N_CLASSES);
  localparam int N_PAIRS = n_pairs(N_CLASSES);

  localparam logic [CLS_W-1:0] HI0    = CLS_W'(N_CLASSES - 1);
  localparam logic [IDX_W-1:0] STRIDE = IDX_W'(N_CLASSES - 1);

  if (N_CLASSES < 2) begin : g_bad_n
    $error("svm_ddag_sequencer: N_CLASSES must be >= 2");
  end

  state_e           state_q, state_d;
  logic [CLS_W-1:0] lo_q, lo_d;
  logic [CLS_W-1:0] hi_q, hi_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] win_q, win_d;
  logic             last;

  logic [WEIGHT_W*N_FEATURES-1:0] rom_weight;
  logic [BIAS_W-1:0]              rom_bias;

  assign last = (hi_q - lo_q) == CLS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= HI0;
      idx_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

  // Counters return to pair 0 whenever EVAL is left, so
  // IDLE/DONE present row 0 and the index never overruns.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = EVAL;
      end
      EVAL: begin
        if (bus.abort) begin
          state_d = IDLE;
          lo_d    = '0;
          hi_d    = HI0;
          idx_d   = '0;
        end else if (bus.svm_ready) begin
          if (last) begin
            state_d = DONE;
            win_d   = bus.svm_class ? hi_q : lo_q;
            lo_d    = '0;
            hi_d    = HI0;
            idx_d   = '0;
          end else if (bus.svm_class) begin
            // Skip the rest of lo's rows: N-1-lo of them.
            lo_d  = lo_q + 1'b1;
            idx_d = idx_q + STRIDE - IDX_W'(lo_q);
          end else begin
            hi_d  = hi_q - 1'b1;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  svm_coeff_rom #(
    .N_PAIRS   (N_PAIRS),
    .N_FEATURES(N_FEATURES),
    .WEIGHT_W  (WEIGHT_W),
    .BIAS_W    (BIAS_W)
  ) u_rom (
    .idx_i   (idx_q),
    .weight_o(rom_weight),
    .bias_o  (rom_bias)
  );

  assign bus.busy     = (state_q == EVAL);
  assign bus.ready    = (state_q == DONE);
  assign bus.pair_idx = idx_q;
  assign bus.pair_lo  = lo_q;
  assign bus.pair_hi  = hi_q;
  assign bus.winner   = win_q;
  assign bus.weight   = rom_weight;
  assign bus.bias     = rom_bias;

  a_pair_idx : assert property (@(posedge clk) disable iff (rst)
    (state_q == EVAL) |-> (lo_q < hi_q &&
      int'(idx_q) == pair_index(int'(lo_q), int'(hi_q), N_CLASSES)));

endmodule

// File: tb/tb_svm_ddag_sequencer.sv
// Bench for svm_ddag_sequencer: N=10, N=2 and N=3 builds share one
// stimulus stream; a candidate-set model checks all three every cycle.
module tb_svm_ddag_sequencer;
  import svm_ddag_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic svm_ready = 1'b0, svm_class = 1'b0;

  always #5 clk = ~clk;

  svm_ddag_sequencer_if #(.N_CLASSES(10)) b10 ();
  svm_ddag_sequencer_if #(.N_CLASSES(2))  b2 ();
  svm_ddag_sequencer_if #(.N_CLASSES(3))  b3 ();

  assign {b10.start, b10.abort, b10.svm_ready, b10.svm_class} =
         {start, abort, svm_ready, svm_class};
  assign {b2.start, b2.abort, b2.svm_ready, b2.svm_class} =
         {start, abort, svm_ready, svm_class};
  assign {b3.start, b3.abort, b3.svm_ready, b3.svm_class} =
         {start, abort, svm_ready, svm_class};

  svm_ddag_sequencer #(.N_CLASSES(10), .N_FEATURES(16),
    .WEIGHT_W(8), .BIAS_W(16))
    u10 (.clk(clk), .rst(rst), .bus(b10.slave));
  svm_ddag_sequencer #(.N_CLASSES(2), .N_FEATURES(16),
    .WEIGHT_W(8), .BIAS_W(16))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  svm_ddag_sequencer #(.N_CLASSES(3), .N_FEATURES(16),
    .WEIGHT_W(8), .BIAS_W(16))
    u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: set of surviving classes per build.
  // The pair is (smallest, largest) survivor; a decision drops one.
  int          NC[3] = '{10, 2, 3};
  logic [15:0] alive[3];
  int          ms[3]   = '{0, 0, 0};
  int          mwin[3] = '{0, 0, 0};

  function automatic logic [15:0] all_classes(int n);
    return 16'((32'd1 << n) - 1);
  endfunction

  function automatic int lowest(logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int highest(logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        ms[m] = 0; mwin[m] = 0; alive[m] = all_classes(NC[m]);
      end else begin
        case (ms[m])
          0: if (start) ms[m] = 1;
          1: begin
            if (abort) begin
              ms[m] = 0; alive[m] = all_classes(NC[m]);
            end else if (svm_ready) begin
              if (svm_class) alive[m][lowest(alive[m])] = 1'b0;
              else           alive[m][highest(alive[m])] = 1'b0;
              if ($countones(alive[m]) == 1) begin
                mwin[m] = lowest(alive[m]);
                ms[m] = 2; alive[m] = all_classes(NC[m]);
              end
            end
          end
          default: ms[m] = 0;
        endcase
      end
    end
  endtask

  string       fn[6] = '{"busy", "ready", "winner", "lo", "hi", "idx"};
  logic [31:0] act[6];
  logic [31:0] exp_v[6];

  initial forever begin
    @(posedge clk);
    #1;
    model_step();
    for (int m = 0; m < 3; m++) begin
      int l, h;
      l = lowest(alive[m]);
      h = highest(alive[m]);
      case (m)
        0: act = '{32'(b10.busy), 32'(b10.ready), 32'(b10.winner),
                   32'(b10.pair_lo), 32'(b10.pair_hi), 32'(b10.pair_idx)};
        1: act = '{32'(b2.busy), 32'(b2.ready), 32'(b2.winner),
                   32'(b2.pair_lo), 32'(b2.pair_hi), 32'(b2.pair_idx)};
        default:
           act = '{32'(b3.busy), 32'(b3.ready), 32'(b3.winner),
                   32'(b3.pair_lo), 32'(b3.pair_hi), 32'(b3.pair_idx)};
      endcase
      exp_v = '{32'(ms[m] == 1), 32'(ms[m] == 2), 32'(mwin[m]),
                32'(l), 32'(h), 32'(pair_index(l, h, NC[m]))};
      for (int f = 0; f < 6; f++)
        check($sformatf("mon N%0d.%s", NC[m], fn[f]), act[f], exp_v[f]);
      if (m == 0) begin
        check("mon N10.bias", 32'(b10.bias),
              coeff_hash(pair_index(l, h, 10), 16) & 32'hFFFF);
        check("mon N10.w0", 32'(b10.weight[7:0]),
              coeff_hash(pair_index(l, h, 10), 0) & 32'hFF);
      end
    end
  end

  task automatic drive(logic s, logic a, logic r, logic c);
    start = s; abort = a; svm_ready = r; svm_class = c;
  endtask

  typedef struct {
    logic cls;
    int   lo;
    int   hi;
    int   idx;
  } vec_t;

  vec_t vec[18];
  int   k;

  initial begin
    vec[0]  = '{1'b0, 0, 9, 0}; vec[1]  = '{1'b0, 0, 8, 1};
    vec[2]  = '{1'b0, 0, 7, 2}; vec[3]  = '{1'b0, 0, 6, 3};
    vec[4]  = '{1'b0, 0, 5, 4}; vec[5]  = '{1'b0, 0, 4, 5};
    vec[6]  = '{1'b0, 0, 3, 6}; vec[7]  = '{1'b0, 0, 2, 7};
    vec[8]  = '{1'b0, 0, 1, 8};
    vec[9]  = '{1'b1, 0, 9, 0};  vec[10] = '{1'b1, 1, 9, 9};
    vec[11] = '{1'b1, 2, 9, 17}; vec[12] = '{1'b1, 3, 9, 24};
    vec[13] = '{1'b1, 4, 9, 30}; vec[14] = '{1'b1, 5, 9, 35};
    vec[15] = '{1'b1, 6, 9, 39}; vec[16] = '{1'b1, 7, 9, 42};
    vec[17] = '{1'b1, 8, 9, 44};

    drive(0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.busy", 32'(b10.busy), 0);
    check("rst.ready", 32'(b10.ready), 0);
    check("rst.winner", 32'(b10.winner), 0);
    check("rst.idx", 32'(b10.pair_idx), 0);
    check("rst.hi", 32'(b10.pair_hi), 9);

    // all-0 run then all-1 run, svm_ready held high
    for (int r = 0; r < 2; r++) begin
      drive(1, 0, 0, 0);
      @(negedge clk);
      for (int s = 0; s < 9; s++) begin
        vec_t v;
        v = vec[r*9+s];
        check($sformatf("tbl%0d.lo", r*9+s), 32'(b10.pair_lo), v.lo);
        check($sformatf("tbl%0d.hi", r*9+s), 32'(b10.pair_hi), v.hi);
        check($sformatf("tbl%0d.idx", r*9+s), 32'(b10.pair_idx), v.idx);
        drive(0, 0, 1, v.cls);
        @(negedge clk);
      end
      drive(0, 0, 0, 0);
      check("tbl.ready", 32'(b10.ready), 1);
      check("tbl.winner", 32'(b10.winner), r ? 9 : 0);
      check("tbl.n2win", 32'(b2.winner), r);
      check("tbl.n3win", 32'(b3.winner), r ? 2 : 0);
      @(negedge clk);
    end

    // alternating 1,0,... with random gaps in svm_ready
    drive(1, 0, 0, 0);
    @(negedge clk);
    for (int d = 0; d < 9; d++) begin
      repeat ($urandom_range(0, 3)) begin
        drive(0, 0, 0, 1'($urandom_range(0, 1)));
        @(negedge clk);
      end
      check("gap.busy", 32'(b10.busy), 1);
      drive(0, 0, 1, d % 2 == 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0);
    check("gap.ready", 32'(b10.ready), 1);
    check("gap.winner", 32'(b10.winner), 5);
    @(negedge clk);

    // abort after 4 decisions, abort together with svm_ready
    drive(1, 0, 0, 0);
    @(negedge clk);
    repeat (4) begin
      drive(0, 0, 1, 0);
      @(negedge clk);
    end
    check("abt.idx4", 32'(b10.pair_idx), 4);
    drive(0, 1, 1, 1);
    @(negedge clk);
    drive(0, 0, 1, 1);
    check("abt.busy", 32'(b10.busy), 0);
    check("abt.ready", 32'(b10.ready), 0);
    check("abt.winner", 32'(b10.winner), 5);
    check("abt.idx", 32'(b10.pair_idx), 0);
    @(negedge clk);
    check("idle_dec.busy", 32'(b10.busy), 0);
    check("idle_dec.idx", 32'(b10.pair_idx), 0);
    drive(1, 0, 0, 1);
    @(negedge clk);
    check("restart.busy", 32'(b10.busy), 1);
    check("restart.idx", 32'(b10.pair_idx), 0);

    // start held high through EVAL; decisions until ready
    k = 0;
    while (b10.ready !== 1'b1 && k < 20) begin
      drive(1, 0, 1, 1);
      @(negedge clk);
      k++;
    end
    check("busy_start.decisions", k, 9);
    check("busy_start.winner", 32'(b10.winner), 9);
    drive(0, 1, 0, 0);
    @(negedge clk);
    check("abort_done.busy", 32'(b10.busy), 0);
    check("abort_done.winner", 32'(b10.winner), 9);
    drive(0, 0, 0, 0);
    @(negedge clk);

    // rst in the middle of EVAL
    drive(1, 0, 0, 0);
    @(negedge clk);
    repeat (3) begin
      drive(0, 0, 1, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    check("midrst.busy", 32'(b10.busy), 0);
    check("midrst.winner", 32'(b10.winner), 0);
    check("midrst.ready", 32'(b10.ready), 0);
    check("midrst.lo", 32'(b10.pair_lo), 0);
    @(negedge clk);

    // random control traffic, checked by the model
    repeat (3000) begin
      drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = 1'($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
